// File: rtl/dmem_responder.sv
// Byte-addressable data memory with a valid/ready request/response handshake and WAIT_CYCLES wait states.
// The RV32 load/store subset assumes DATA_W=32; define DMEM_MISALIGN_TRAP_EN to make misaligned accesses error out.
module dmem_responder #(
  parameter int DATA_W      = 32,
  parameter int DM_ADDRESS  = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);

  localparam int WORDS = 2 ** (DM_ADDRESS - 2);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state, state_next;
  logic [3:0]              cnt;
  logic                    we_q;
  logic [DM_ADDRESS-1:0]   addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [2:0]              funct3_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    err_q;
  logic [DATA_W-1:0]       mem [WORDS];

  logic                    accept, enter_resp;
  logic                    a_we, a_legal, a_mis, a_err;
  logic [DM_ADDRESS-1:0]   a_addr, eff_addr;
  logic [DATA_W-1:0]       a_wdata, wdata_al, rword, shifted, load_val;
  logic [2:0]              a_funct3;
  logic [3:0]              byte_en;
  logic                    mem_we;

  assign accept = req_valid && (state == S_IDLE);
  assign enter_resp = (state == S_IDLE && accept && WAIT_CYCLES == 0) ||
                      (state == S_WAIT && cnt == 4'd0);

  // With zero wait states the access happens on the accept edge, before the latches hold the request.
  assign a_we     = (state == S_IDLE) ? req_we     : we_q;
  assign a_addr   = (state == S_IDLE) ? req_addr   : addr_q;
  assign a_wdata  = (state == S_IDLE) ? req_wdata  : wdata_q;
  assign a_funct3 = (state == S_IDLE) ? req_funct3 : funct3_q;

  always_comb begin
    a_legal  = 1'b0;
    a_mis    = 1'b0;
    eff_addr = a_addr;
    byte_en  = 4'b0000;
    wdata_al = a_wdata;
    load_val = '0;
    if (a_we) a_legal = (a_funct3 == 3'b000) || (a_funct3 == 3'b001) || (a_funct3 == 3'b010);
    else      a_legal = (a_funct3 != 3'b011) && (a_funct3 != 3'b110) && (a_funct3 != 3'b111);
    a_mis = (a_funct3[1:0] == 2'b01 && a_addr[0]) || (a_funct3[1:0] == 2'b10 && a_addr[1:0] != 2'b00);
`ifdef DMEM_MISALIGN_TRAP_EN
    a_err = !a_legal || a_mis;
`else
    a_err = !a_legal;
    if (a_funct3[1:0] == 2'b01) eff_addr[0] = 1'b0;
    if (a_funct3[1:0] == 2'b10) eff_addr[1:0] = 2'b00;
`endif
    case (a_funct3[1:0])
      2'b00:   begin byte_en = 4'b0001 << eff_addr[1:0];       wdata_al = {4{a_wdata[7:0]}};  end
      2'b01:   begin byte_en = 4'b0011 << {eff_addr[1], 1'b0}; wdata_al = {2{a_wdata[15:0]}}; end
      default: begin byte_en = 4'b1111;                        wdata_al = a_wdata;            end
    endcase
    rword   = mem[eff_addr[DM_ADDRESS-1:2]];
    shifted = rword >> {eff_addr[1:0], 3'b000};
    case (a_funct3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = shifted;
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = '0;
    endcase
  end

  // A reset on the committing edge abandons the store.
  assign mem_we = enter_resp && a_we && !a_err && !reset;

  // NOTE: the array has no reset branch, so it maps onto plain RAM; only control state is cleared.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (byte_en[b]) mem[eff_addr[DM_ADDRESS-1:2]][8*b +: 8] <= wdata_al[8*b +: 8];
    end
  end

  // NOTE: every register here uses <= so all updates see the pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt      <= CNT_INIT;
        we_q     <= req_we;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rdata_q <= (a_we || a_err) ? '0 : load_val;
        err_q   <= a_err;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt == 4'd0) state_next = S_RESP;
      S_RESP:  if (resp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    busy       = (state != S_IDLE);
    resp_valid = (state == S_RESP);
    resp_rdata = (state == S_RESP) ? rdata_q : '0;
    resp_err   = (state == S_RESP) ? err_q : 1'b0;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (default parameters, WAIT_CYCLES=2).
// Misalignment expectations follow DMEM_MISALIGN_TRAP_EN when it is defined for the build.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid, resp_ready, resp_err, busy;
  logic [31:0] resp_rdata;

  int checks = 0;
  int fails  = 0;

  dmem_responder dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  // One transaction: present, accept, scramble inputs, wait for response, optionally stall, then retire.
  task automatic xact(input string tag, input logic we, input logic [8:0] addr,
                      input logic [31:0] wd, input logic [2:0] f3, input int hold,
                      output logic [31:0] rd, output logic err);
    int lat;
    logic [31:0] rd0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_funct3 = f3;
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wd; req_funct3 = 3'b111;
    check({tag, ".wait_busy"}, {busy, req_ready, resp_valid}, 32'b100);
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd3);
    rd  = resp_rdata;
    err = resp_err;
    rd0 = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".stall"}, {resp_valid, req_ready, busy}, 32'b101);
      check({tag, ".stall_rdata"}, resp_rdata, rd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, ".retire"}, {req_ready, resp_valid, resp_err, busy}, 32'b1000);
    check({tag, ".retire_rdata"}, resp_rdata, 32'd0);
  endtask

  logic [31:0] rd;
  logic        err;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_funct3 = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", {req_ready, resp_valid, resp_err, busy}, 32'b1000);
    check("reset_rdata", resp_rdata, 32'd0);
    reset = 1'b0;

    xact("sw10", 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 0, rd, err);
    check("sw10.err", 32'(err), 32'd0);
    check("sw10.rdata", rd, 32'd0);
    xact("lw10", 1'b0, 9'h010, 32'h0, 3'b010, 0, rd, err);
    check("lw10.rdata", rd, 32'hDEADBEEF);

    xact("sb11", 1'b1, 9'h011, 32'h00000080, 3'b000, 0, rd, err);
    xact("lb11", 1'b0, 9'h011, 32'h0, 3'b000, 0, rd, err);
    check("lb11.rdata", rd, 32'hFFFFFF80);
    xact("lbu11", 1'b0, 9'h011, 32'h0, 3'b100, 0, rd, err);
    check("lbu11.rdata", rd, 32'h00000080);
    xact("lw10b", 1'b0, 9'h010, 32'h0, 3'b010, 0, rd, err);
    check("lw10b.rdata", rd, 32'hDEAD80EF);

    xact("lh12", 1'b0, 9'h012, 32'h0, 3'b001, 0, rd, err);
    check("lh12.rdata", rd, 32'hFFFFDEAD);
    xact("lhu12", 1'b0, 9'h012, 32'h0, 3'b101, 0, rd, err);
    check("lhu12.rdata", rd, 32'h0000DEAD);
    xact("ld011", 1'b0, 9'h010, 32'h0, 3'b011, 0, rd, err);
    check("ld011.err", 32'(err), 32'd1);
    check("ld011.rdata", rd, 32'd0);

    // Illegal store must not write; halfword store to upper lanes.
    xact("st011", 1'b1, 9'h010, 32'h11111111, 3'b011, 0, rd, err);
    check("st011.err", 32'(err), 32'd1);
    xact("sh12", 1'b1, 9'h012, 32'hAAAA1234, 3'b001, 0, rd, err);
    xact("lw10c", 1'b0, 9'h010, 32'h0, 3'b010, 0, rd, err);
    check("lw10c.rdata", rd, 32'h123480EF);

    // Backpressure: five stalled cycles in RESP.
    xact("bp", 1'b0, 9'h010, 32'h0, 3'b010, 5, rd, err);
    check("bp.rdata", rd, 32'h123480EF);

    // Reset on the edge that would commit a store.
    xact("sw20", 1'b1, 9'h020, 32'hCAFEF00D, 3'b010, 0, rd, err);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h020; req_wdata = 32'h12345678; req_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_wait", {req_ready, resp_valid, resp_err, busy}, 32'b1000);
    repeat (3) @(negedge clk);
    check("rst_wait_quiet", 32'(resp_valid), 32'd0);
    xact("lw20", 1'b0, 9'h020, 32'h0, 3'b010, 0, rd, err);
    check("lw20.rdata", rd, 32'hCAFEF00D);

    // Reset while a response is pending drops it.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h010; req_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_resp_pre", 32'(resp_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_resp", {req_ready, resp_valid, resp_err, busy}, 32'b1000);
    check("rst_resp_rdata", resp_rdata, 32'd0);

    // Misaligned word load.
    xact("lw13", 1'b0, 9'h013, 32'h0, 3'b010, 0, rd, err);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("lw13.err", 32'(err), 32'd1);
    check("lw13.rdata", rd, 32'd0);
`else
    check("lw13.err", 32'(err), 32'd0);
    check("lw13.rdata", rd, 32'h123480EF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
